// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux with explicit-select or round-robin arbitration into one output register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: a held word with out_ready low drops every in_ready; a full register reloads in the same cycle it drains.
module stream_mux_rr #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src,
  output logic                    sel_err
);

  // Index of the most recently granted channel.
  // After reset it points at the last channel, so the round-robin search starts at channel 0.
  logic [SEL_W-1:0] rr_ptr;

  logic             load_en;
  logic             sel_ok;
  logic             sel_hit;
  logic             rr_hi_found;
  logic [SEL_W-1:0] rr_hi_idx;
  logic             rr_lo_found;
  logic [SEL_W-1:0] rr_lo_idx;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             in_xfer;

  // The register can accept a word when it is empty or is draining this cycle.
  always_comb begin
    load_en = !out_valid || out_ready;
  end

  // Explicit select: range check, plus the valid bit of the selected channel.
  // The loop compares sel against each channel index rather than using sel as an index,
  // so an out-of-range sel never produces an out-of-range access.
  always_comb begin
    sel_ok  = (int'(sel) < NUM_IN);
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == sel) begin
        sel_hit = in_valid[i];
      end
    end
  end

  // Round-robin search, split into two passes.
  // The first pass finds the lowest valid channel above rr_ptr.
  // The second pass finds the lowest valid channel overall, which is the wrap-around case.
  always_comb begin
    rr_hi_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_found = 1'b0;
    rr_lo_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!rr_hi_found && in_valid[i] && (SEL_W'(i) > rr_ptr)) begin
        rr_hi_found = 1'b1;
        rr_hi_idx   = SEL_W'(i);
      end
      if (!rr_lo_found && in_valid[i]) begin
        rr_lo_found = 1'b1;
        rr_lo_idx   = SEL_W'(i);
      end
    end
  end

  // Pick the winner according to the current mode.
  // Mode and sel act on this cycle's grant with no pipeline delay.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      grant_vld = sel_ok && sel_hit;
      grant_idx = sel;
    end else if (rr_hi_found) begin
      grant_vld = 1'b1;
      grant_idx = rr_hi_idx;
    end else begin
      grant_vld = rr_lo_found;
      grant_idx = rr_lo_idx;
    end
  end

  // One-hot ready for the granted channel, and the data mux.
  // Only the granted channel's data is routed, so other channels cannot reach the outputs.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == grant_idx) begin
        in_ready[i] = grant_vld && load_en && !rst;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // An input transfer happens exactly when one ready bit is raised, because a raised ready implies a valid.
  always_comb begin
    in_xfer = |in_ready;
  end

  // Output register, round-robin pointer and select-error pulse.
  // Reset is asynchronous, so a held word is discarded as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      rr_ptr    <= SEL_W'(NUM_IN - 1);
    end else begin
      sel_err <= load_en && !mode && !sel_ok;
      if (in_xfer) begin
        out_data  <= grant_data;
        out_src   <= grant_idx;
        out_valid <= 1'b1;
        rr_ptr    <= grant_idx;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a default 3-channel instance and an 8-bit 5-channel instance.
// Inputs are driven 1 time unit after each rising edge, and outputs are sampled there as well.
// Summary line reports passed/total checks.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;

  logic [95:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_src;
  logic        sel_err;

  logic [39:0] b_in_data;
  logic [4:0]  b_in_valid;
  logic [4:0]  b_in_ready;
  logic        b_mode;
  logic [2:0]  b_sel;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [2:0]  b_out_src;
  logic        b_sel_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  stream_mux_rr u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .sel_err   (sel_err)
  );

  stream_mux_rr #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_src   (b_out_src),
    .sel_err   (b_sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] v);
    in_data[ch*32 +: 32] = v;
  endtask

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    in_valid    = 3'b111;
    mode        = 1'b1;
    sel         = 2'd0;
    out_ready   = 1'b1;
    b_in_data   = '0;
    b_in_valid  = '0;
    b_mode      = 1'b0;
    b_sel       = 3'd0;
    b_out_ready = 1'b1;
    set_ch(0, 32'hA5A5_0000);
    set_ch(1, 32'hA5A5_0001);
    set_ch(2, 32'hA5A5_0002);

    // Reset state.
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_out_src",   32'(out_src),   32'h0);
    chk("rst_sel_err",   32'(sel_err),   32'h0);
    step();
    step();
    rst = 1'b0;

    // Explicit select of channel 1.
    mode = 1'b0;
    sel  = 2'd1;
    #1;
    chk("m0_in_ready", 32'(in_ready), 32'h2);
    step();
    chk("m0_out_valid", 32'(out_valid), 32'h1);
    chk("m0_out_data",  out_data,       32'hA5A5_0001);
    chk("m0_out_src",   32'(out_src),   32'h1);

    // Drain the register, then apply an out-of-range select.
    in_valid = 3'b000;
    step();
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    sel      = 2'd3;
    in_valid = 3'b111;
    #1;
    chk("bad_sel_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("bad_sel_err",       32'(sel_err),   32'h1);
    chk("bad_sel_out_valid", 32'(out_valid), 32'h0);
    sel      = 2'd0;
    in_valid = 3'b000;
    step();
    chk("bad_sel_err_clear", 32'(sel_err), 32'h0);

    // Round robin with all channels valid: 0,1,2,0,1,2 back to back.
    rst = 1'b1;
    step();
    rst      = 1'b0;
    mode     = 1'b1;
    in_valid = 3'b111;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_out_valid", 32'(out_valid), 32'h1);
      chk("rr_out_src",   32'(out_src),   32'(i % 3));
      chk("rr_out_data",  out_data,       32'hA5A5_0000 + 32'(i % 3));
    end

    // Round robin on channels 0 and 2, with the output stalled after the first load.
    rst = 1'b1;
    step();
    rst       = 1'b0;
    in_valid  = 3'b101;
    out_ready = 1'b0;
    step();
    chk("stall_load_src", 32'(out_src), 32'h0);
    set_ch(0, 32'h1111_0000);
    set_ch(1, 32'h2222_0001);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    chk("stall_out_data",  out_data,       32'hA5A5_0000);
    chk("stall_out_src",   32'(out_src),   32'h0);
    chk("stall_out_valid", 32'(out_valid), 32'h1);
    set_ch(2, 32'h3333_0002);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'h4);
    step();
    chk("release_src2",  32'(out_src), 32'h2);
    chk("release_data2", out_data,     32'h3333_0002);
    step();
    chk("release_src0",  32'(out_src), 32'h0);
    chk("release_data0", out_data,     32'h1111_0000);

    // Reset between clock edges while a word is held.
    out_ready = 1'b0;
    in_valid  = 3'b000;
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data",  out_data,       32'h0);
    #2 rst = 1'b0;
    in_valid  = 3'b111;
    out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    step();
    chk("post_rst_src", 32'(out_src), 32'h0);

    // A mode change takes effect in the same cycle's grant (rr_ptr is now 0).
    mode = 1'b0;
    sel  = 2'd2;
    #1;
    chk("modechg_m0_ready", 32'(in_ready), 32'h4);
    mode = 1'b1;
    #1;
    chk("modechg_m1_ready", 32'(in_ready), 32'h2);
    in_valid = 3'b000;
    step();

    // Wide instance: only channel 4 is valid.
    b_mode     = 1'b1;
    b_in_valid = 5'b10000;
    b_in_data  = 40'h00_11_22_33_44;
    for (int i = 0; i < 3; i++) begin
      b_in_data[39:32] = 8'h50 + 8'(i);
      #1;
      chk("b_in_ready", 32'(b_in_ready), 32'h10);
      step();
      chk("b_out_src",   32'(b_out_src),   32'h4);
      chk("b_out_data",  32'(b_out_data),  32'h50 + 32'(i));
      chk("b_out_valid", 32'(b_out_valid), 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
